truth_table_sweeper: RTL
========================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL use a single clock domain; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  async active-low reset.
REQ-004 start  input  1  sweep request, sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of an active sweep.
REQ-006 settle  input  4  extra wait cycles per row before sampling (0-15).
REQ-007 expected  input  16  golden truth table, bit i = expected output for row i.
REQ-008 f_in  input  1  output of the combinational function under test.
REQ-009 w, x, y, z  output  1 each  drive of the function under test; w = row bit 3 (MSB), z = row bit 0.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  high after a completed sweep, until the next accepted start.
REQ-012 row_valid  output  1  one-cycle pulse on each sample.
REQ-013 row_idx  output  4  row currently driven or sampled.
REQ-014 table_q  output  16  captured truth table, bit i = f_in sampled at row i.
REQ-015 err_cnt  output  5  count of rows where f_in != expected[i] (range 0-16).
REQ-016 pass  output  1  done AND err_cnt == 0.

Function
REQ-017 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-018 Row counter SHALL be 5 bits internally so that termination after row 15 is unambiguous; the counter SHALL never wrap to row 0 mid-sweep.
REQ-019 IDLE or DONE with start=1 SHALL, on that edge, perform all of the following:
- go to SETTLE;
- set row=0, drive wxyz=0000;
- clear table_q and err_cnt, clear done;
- load the settle counter with settle.
REQ-020 SETTLE behaviour:
- cnt != 0: decrement cnt, stay in SETTLE;
- cnt == 0: go to SAMPLE.
REQ-021 SAMPLE behaviour, in one cycle:
- table_q[row] <= f_in;
- err_cnt increments if f_in != expected[row];
- row_valid=1.
REQ-022 SAMPLE exit:
- row < 15: row increments, wxyz updates on the same edge, cnt reloads from settle, go to SETTLE;
- row == 15: go to DONE.
REQ-023 Cycles per row SHALL be settle+2; a full sweep SHALL be 16*(settle+2) cycles from the start edge to DONE entry.
REQ-024 settle SHALL be captured at each row reload; changing it mid-sweep affects only subsequent rows.
REQ-025 busy SHALL be 1 in SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-026 DONE SHALL hold done=1 and hold table_q and err_cnt stable until start.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort in SETTLE or SAMPLE SHALL force IDLE on the next edge:
- drive wxyz=0000 and done=0;
- retain the partial table_q and err_cnt;
- suppress the sample of that cycle.
REQ-029 abort and start asserted together in IDLE or DONE: abort SHALL win and the state SHALL go to IDLE with no sweep started.
REQ-030 All outputs SHALL be registered; f_in is treated as asynchronous combinational feedback that is valid by the SAMPLE cycle.

Reset
REQ-031 rst_n=0 SHALL immediately force the following, regardless of state or mid-sweep progress:
- IDLE;
- wxyz=0000, row_idx=0;
- busy=0, done=0, row_valid=0, pass=0;
- table_q=16'h0000, err_cnt=0.
REQ-032 After rst_n deasserts, the first start SHALL be honoured on the next clk edge.

Verification
REQ-033 Golden function f=(~y&z)|(w&~x)|(x&y&~z) on f_in, settle=0, expected=16'h6F62, pulse start. Required response:
- done after 32 cycles;
- table_q=16'h6F62, err_cnt=0, pass=1;
- 16 row_valid pulses with row_idx 0..15.
REQ-034 Same function, expected=16'h6F63. Required response:
- err_cnt=1, pass=0;
- table_q=16'h6F62.
REQ-035 settle=15. Required response:
- done exactly 272 cycles after start;
- wxyz stable for 17 cycles per row.
REQ-036 abort asserted during row 5 SETTLE. Required response:
- IDLE on the next edge, busy=0, done=0;
- table_q holds only rows 0-4.
REQ-037 Reset mid-sweep. Required response:
- asynchronous clear of all outputs;
- a subsequent start completes a normal sweep.
REQ-038 start held high throughout a sweep. Required response:
- no restart while busy;
- a new sweep starts the cycle after DONE entry, clearing done and table_q.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Drives all 16 input combinations onto a 4-input combinational function,
// samples its output per row after a programmable settle delay and grades it.
module truth_table_sweeper (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  settle,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic        row_valid,
  output logic [3:0]  row_idx,
  output logic [15:0] table_q,
  output logic [4:0]  err_cnt,
  output logic        pass,
  output logic [1:0]  dbg_state
);

  // Handshake: start is a level sampled only in IDLE/DONE; row_valid is high
  // for exactly the SAMPLE cycle, during which row_idx names the row whose
  // f_in is captured at the closing edge.
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tbl_q, tbl_d;
  logic [4:0]  err_q, err_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        pass_q, pass_d;
  logic        mismatch;

  assign mismatch = f_in ^ expected[row_q[3:0]];

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    err_d   = err_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && abort) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end else if (start) begin
          state_d = S_SETTLE;
          row_d   = 5'd0;
          cnt_d   = settle;
          tbl_d   = 16'h0000;
          err_d   = 5'd0;
          done_d  = 1'b0;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          row_d   = 5'd0;
          done_d  = 1'b0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
          row_d   = 5'd0;
          done_d  = 1'b0;
        end else begin
          tbl_d[row_q[3:0]] = f_in;
          err_d             = err_q + {4'b0000, mismatch};
          // Five-bit row: stop at 15 instead of letting a nibble wrap to 0.
          if (row_q < 5'd15) begin
            row_d   = row_q + 5'd1;
            cnt_d   = settle;
            state_d = S_SETTLE;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d  = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
  assign valid_d = (state_d == S_SAMPLE);
  assign pass_d  = done_d && (err_d == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= 5'd0;
      cnt_q   <= 4'd0;
      tbl_q   <= 16'h0000;
      err_q   <= 5'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      pass_q  <= pass_d;
    end
  end

  assign {w, x, y, z} = row_q[3:0];
  assign row_idx      = row_q[3:0];
  assign busy         = busy_q;
  assign done         = done_q;
  assign row_valid    = valid_q;
  assign table_q      = tbl_q;
  assign err_cnt      = err_q;
  assign pass         = pass_q;
  assign dbg_state    = state_q;

endmodule
